// File: rtl/localbus_master_pkg.sv
// localbus_master_pkg: localbus widths, FSM state encoding and responder register offsets
package localbus_master_pkg;
  localparam int LB_ADDR_W = 32;
  localparam int LB_DATA_W = 32;
  localparam logic [LB_ADDR_W-1:0] LB_REG_STATUS = 32'h0000_0004;
  localparam logic [LB_ADDR_W-1:0] LB_REG_IN_CNT = 32'h0000_000C;
  localparam logic [LB_ADDR_W-1:0] LB_REG_OUT_CNT = 32'h0000_0014;
  typedef enum logic [1:0] {IDLE_S, REQ_S, REL_S} lb_state_e;
endpackage

// File: rtl/localbus_master_if.sv
// localbus_master_if: host command/response side and cfg responder side of the localbus master
interface localbus_master_if;
  import localbus_master_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_rw;
  logic [LB_ADDR_W-1:0] cmd_addr;
  logic [LB_DATA_W-1:0] cmd_wdata;
  logic rsp_valid;
  logic [LB_DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  logic cfg_cs_n;
  logic cfg_rw;
  logic [LB_ADDR_W-1:0] cfg_addr;
  logic [LB_DATA_W-1:0] cfg_wdata;
  logic cfg_ack_n;
  logic [LB_DATA_W-1:0] cfg_rdata;
  logic busy;
  modport master (
    input cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cfg_ack_n, cfg_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, cfg_cs_n, cfg_rw, cfg_addr, cfg_wdata, busy
  );
  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cfg_ack_n, cfg_rdata,
    input cmd_ready, rsp_valid, rsp_rdata, rsp_err, cfg_cs_n, cfg_rw, cfg_addr, cfg_wdata, busy
  );
endinterface

// File: rtl/localbus_master_sync.sv
// sync_sig: 2-flop synchronizer with active-low synchronous reset to RST_VAL
module sync_sig #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_ff;
  always_ff @(posedge clk)
    r_ff <= !rst_n ? {2{RST_VAL}} : {r_ff[0], i_d};
  assign o_q = r_ff[1];
endmodule

// File: rtl/localbus_master.sv
// localbus_master: single-beat cfg command to cs_n/ack_n four-phase localbus request with
// per-phase timeout so a dead responder aborts instead of hanging the host.
module localbus_master
  import localbus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit SYNC_ACK = 1'b1
) (
  input logic clk,
  input logic rst,
  localbus_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  lb_state_e r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic r_cs_n, w_cs_n_nx;
  logic r_rw, w_rw_nx;
  logic [LB_ADDR_W-1:0] r_addr, w_addr_nx;
  logic [LB_DATA_W-1:0] r_wdata, w_wdata_nx;
  logic [LB_DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nx;
  logic r_rsp_err, w_rsp_err_nx;
  logic r_rsp_valid, w_rsp_valid_nx;
  logic r_cmd_ready, w_cmd_ready_nx;
  logic r_busy;
  logic w_ack_s, w_fire, w_tmo;
  if (SYNC_ACK) begin : g_sync
    sync_sig #(.RST_VAL(1'b1)) u_ack_sync (
      .clk  (clk),
      .rst_n(~rst),
      .i_d  (bus.cfg_ack_n),
      .o_q  (w_ack_s)
    );
  end else begin : g_direct
    assign w_ack_s = bus.cfg_ack_n;
  end
  assign w_fire = bus.cmd_valid & r_cmd_ready;
  assign w_tmo = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  // ack seen wins over a same-cycle timeout in both waiting states
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt;
    w_cs_n_nx = r_cs_n;
    w_rw_nx = r_rw;
    w_addr_nx = r_addr;
    w_wdata_nx = r_wdata;
    w_rsp_rdata_nx = r_rsp_rdata;
    w_rsp_err_nx = r_rsp_err;
    w_rsp_valid_nx = 1'b0;
    case (r_state)
      IDLE_S: if (w_fire) begin
        w_rw_nx = bus.cmd_rw;
        w_addr_nx = bus.cmd_addr;
        w_wdata_nx = bus.cmd_wdata;
        w_cs_n_nx = 1'b0;
        w_cnt_nx = '0;
        w_state_nx = REQ_S;
      end
      REQ_S: if (!w_ack_s || w_tmo) begin
        w_rsp_rdata_nx = (!w_ack_s && r_rw) ? bus.cfg_rdata : '0;
        w_rsp_err_nx = w_ack_s;
        w_cs_n_nx = 1'b1;
        w_cnt_nx = '0;
        w_state_nx = REL_S;
      end else begin
        w_cnt_nx = r_cnt + CW'(1);
      end
      REL_S: if (w_ack_s || w_tmo) begin
        w_rsp_rdata_nx = w_ack_s ? r_rsp_rdata : '0;
        w_rsp_err_nx = r_rsp_err | !w_ack_s;
        w_rsp_valid_nx = 1'b1;
        w_cnt_nx = '0;
        w_state_nx = IDLE_S;
      end else begin
        w_cnt_nx = r_cnt + CW'(1);
      end
      default: w_state_nx = IDLE_S;
    endcase
    w_cmd_ready_nx = (r_state == IDLE_S) && w_ack_s && !w_fire;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE_S;
      r_cnt <= '0;
      r_cs_n <= 1'b1;
      r_rw <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      r_cs_n <= w_cs_n_nx;
      r_rw <= w_rw_nx;
      r_addr <= w_addr_nx;
      r_wdata <= w_wdata_nx;
      r_rsp_rdata <= w_rsp_rdata_nx;
      r_rsp_err <= w_rsp_err_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_cmd_ready <= w_cmd_ready_nx;
      r_busy <= w_state_nx != IDLE_S;
    end
  end
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err = r_rsp_err;
  assign bus.cfg_cs_n = r_cs_n;
  assign bus.cfg_rw = r_rw;
  assign bus.cfg_addr = r_addr;
  assign bus.cfg_wdata = r_wdata;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_localbus_master.sv
// tb_localbus_master: directed checks of a synced-ack (0) and direct-ack (1) master, each with
// a behavioural responder (2-flop cs sync, 3-cycle decode, ack while cs low; mode 1 silent, 2 stuck).
module tb_localbus_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid [2];
  logic cmd_rw [2];
  logic [31:0] cmd_addr [2];
  logic [31:0] cmd_wdata [2];
  int mode [2];
  logic o_ready [2];
  logic o_rv [2];
  logic o_err [2];
  logic o_cs_n [2];
  logic o_rw [2];
  logic o_busy [2];
  logic [31:0] o_rdata [2];
  logic [31:0] o_addr [2];
  logic [31:0] o_wdata [2];
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localbus_master_if bus ();
    logic [1:0] cs_s;
    logic [1:0] dcnt;
    logic ack_r;
    logic [31:0] rd_r;
    logic [31:0] mem [256];
    logic [255:0] wv;
    logic [7:0] idx;
    localbus_master #(.TIMEOUT_CYCLES(16), .SYNC_ACK(g == 0)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign idx = bus.cfg_addr[9:2];
    assign bus.cmd_valid = cmd_valid[g];
    assign bus.cmd_rw = cmd_rw[g];
    assign bus.cmd_addr = cmd_addr[g];
    assign bus.cmd_wdata = cmd_wdata[g];
    assign bus.cfg_ack_n = mode[g] == 2 ? 1'b0 : mode[g] == 1 ? 1'b1 : ack_r;
    assign bus.cfg_rdata = ack_r ? 32'hDEAD_BEEF : rd_r;
    assign o_ready[g] = bus.cmd_ready;
    assign o_rv[g] = bus.rsp_valid;
    assign o_err[g] = bus.rsp_err;
    assign o_cs_n[g] = bus.cfg_cs_n;
    assign o_rw[g] = bus.cfg_rw;
    assign o_busy[g] = bus.busy;
    assign o_rdata[g] = bus.rsp_rdata;
    assign o_addr[g] = bus.cfg_addr;
    assign o_wdata[g] = bus.cfg_wdata;
    always @(posedge clk) begin
      cs_s <= {cs_s[0], bus.cfg_cs_n};
      if (rst) begin
        cs_s <= 2'b11;
        dcnt <= 2'd0;
        ack_r <= 1'b1;
        rd_r <= 32'h0;
        wv <= '0;
      end else if (cs_s[1]) begin
        dcnt <= 2'd0;
        ack_r <= 1'b1;
      end else if (dcnt != 2'd3) begin
        dcnt <= dcnt + 2'd1;
      end else if (ack_r) begin
        ack_r <= 1'b0;
        rd_r <= wv[idx] ? mem[idx] : {21'h0, idx, 3'b010};
        if (!bus.cfg_rw) begin
          mem[idx] <= bus.cfg_wdata;
          wv[idx] <= 1'b1;
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // one command on master d; sw_at/sw_mode switch the responder mode that many negedges after the handshake
  task automatic xact(input int d, input string tag, input logic rw, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_lat, input int exp_cs, input int sw_at, input int sw_mode);
    int n, lat, nv, cs_lo, early;
    logic stable, er;
    logic [31:0] rd;
    n = 0; lat = -1; nv = 0; cs_lo = 0; early = 0; stable = 1'b1; er = 1'b0; rd = 32'h0;
    @(negedge clk);
    cmd_valid[d] = 1'b1; cmd_rw[d] = rw; cmd_addr[d] = a; cmd_wdata[d] = wd;
    while (!o_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, o_ready[d], 1);
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) cmd_valid[d] = 1'b0;
      if (i == sw_at) mode[d] = sw_mode;
      if (!o_cs_n[d]) begin
        cs_lo++;
        if (o_addr[d] !== a || o_rw[d] !== rw || o_wdata[d] !== wd) stable = 1'b0;
      end
      if (lat < 0 && o_ready[d]) early++;
      if (o_rv[d]) begin
        nv++;
        if (lat < 0) begin
          lat = i; rd = o_rdata[d]; er = o_err[d];
        end
      end
      if (lat >= 0 && i >= lat + 3) break;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rsp_count"}, nv, 1);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, er, exp_err);
    chk({tag, "_cfg_stable"}, stable, 1);
    chk({tag, "_cs_low_cycles"}, cs_lo, exp_cs);
    chk({tag, "_ready_while_busy"}, early, 0);
    chk({tag, "_rdata_held"}, o_rdata[d], exp_rd);
    chk({tag, "_err_held"}, o_err[d], exp_err);
  endtask
  initial begin
    logic b_rw [4];
    logic [31:0] b_addr [4], b_wd [4], b_exp [4], got [4];
    logic prev_cs, hs;
    int k, nrsp, ncs, cs_cyc, bad, n, nv;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_rw[d] = 1'b0; cmd_addr[d] = 32'h0; cmd_wdata[d] = 32'h0; mode[d] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_cs_n", o_cs_n[0], 1);
    chk("rst_cmd_ready", o_ready[0], 0);
    chk("rst_rsp_valid", o_rv[0], 0);
    chk("rst_busy", o_busy[0], 0);
    chk("rst_rdata", o_rdata[0], 0);
    chk("rst_addr", o_addr[0], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_up", o_ready[0], 1);
    xact(0, "s_wr", 1'b0, 32'h4, 32'hA5A5_0001, 32'h0, 1'b0, 15, 9, -1, 0);
    xact(0, "s_rd", 1'b1, 32'h14, 32'h0, 32'h0000_002A, 1'b0, 15, 9, -1, 0);
    xact(0, "s_rd_back", 1'b1, 32'h4, 32'h0, 32'hA5A5_0001, 1'b0, 15, 9, -1, 0);
    mode[0] = 1;
    xact(0, "s_tmo", 1'b1, 32'h10, 32'h0, 32'h0, 1'b1, 17, 16, -1, 0);
    mode[0] = 0;
    xact(0, "s_after_tmo", 1'b1, 32'h14, 32'h0, 32'h0000_002A, 1'b0, 15, 9, -1, 0);
    // back-to-back: cmd_valid stays high, fields advance right after each handshake
    b_rw = '{1'b0, 1'b1, 1'b0, 1'b1};
    b_addr = '{32'h8, 32'h8, 32'hC, 32'hC};
    b_wd = '{32'h1111_0008, 32'h0, 32'h2222_000C, 32'h0};
    b_exp = '{32'h0, 32'h1111_0008, 32'h0, 32'h2222_000C};
    k = 0; hs = 1'b0; nrsp = 0; ncs = 0; cs_cyc = 0; bad = 0; prev_cs = 1'b1;
    @(negedge clk);
    cmd_rw[0] = b_rw[0]; cmd_addr[0] = b_addr[0]; cmd_wdata[0] = b_wd[0]; cmd_valid[0] = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (hs) begin
        k++;
        hs = 1'b0;
        if (k < 4) begin
          cmd_rw[0] = b_rw[k]; cmd_addr[0] = b_addr[k]; cmd_wdata[0] = b_wd[k];
        end else cmd_valid[0] = 1'b0;
      end
      if (cmd_valid[0] && o_ready[0]) hs = 1'b1;
      if (o_rv[0]) begin
        if (nrsp < 4) got[nrsp] = o_rdata[0];
        nrsp++;
      end
      if (prev_cs && !o_cs_n[0]) ncs++;
      if (!o_cs_n[0]) cs_cyc++;
      prev_cs = o_cs_n[0];
      if (o_ready[0] && o_busy[0]) bad++;
      @(negedge clk);
    end
    chk("b2b_accepted", k, 4);
    chk("b2b_rsp_count", nrsp, 4);
    chk("b2b_cs_falls", ncs, 4);
    chk("b2b_cs_low_cycles", cs_cyc, 36);
    chk("b2b_ready_while_busy", bad, 0);
    for (int j = 0; j < 4; j++) chk($sformatf("b2b_rsp%0d", j), got[j], b_exp[j]);
    // reset while in REQ_S
    cmd_rw[0] = 1'b1; cmd_addr[0] = 32'h14; cmd_valid[0] = 1'b1;
    n = 0;
    while (!o_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    chk("r6_pre_cs_n", o_cs_n[0], 0);
    chk("r6_pre_busy", o_busy[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk("r6_cs_n", o_cs_n[0], 1);
    chk("r6_busy", o_busy[0], 0);
    chk("r6_ready", o_ready[0], 0);
    chk("r6_rsp_valid", o_rv[0], 0);
    chk("r6_rdata", o_rdata[0], 0);
    chk("r6_err", o_err[0], 0);
    chk("r6_addr", o_addr[0], 0);
    chk("r6_rw", o_rw[0], 0);
    rst = 1'b0;
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_rv[0]) nv++;
    end
    chk("r6_no_rsp", nv, 0);
    chk("r6_ready_after", o_ready[0], 1);
    // direct ack: both synchronizer stages of each edge disappear
    xact(1, "a_wr", 1'b0, 32'h4, 32'hA5A5_0001, 32'h0, 1'b0, 11, 7, -1, 0);
    xact(1, "a_rd", 1'b1, 32'h14, 32'h0, 32'h0000_002A, 1'b0, 11, 7, -1, 0);
    mode[1] = 1;
    xact(1, "a_stuck", 1'b0, 32'h4, 32'h5A5A_0002, 32'h0, 1'b1, 32, 16, 16, 2);
    chk("a_stuck_ready", o_ready[1], 0);
    repeat (5) @(negedge clk);
    chk("a_stuck_ready_hold", o_ready[1], 0);
    mode[1] = 0;
    repeat (2) @(negedge clk);
    chk("a_released_ready", o_ready[1], 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
